fifo_wr_arbiter: RTL
====================

Name: fifo_wr_arbiter

Overview:
Write-side arbiter and sequencer for the async FIFO's write port, in the FIFO write-clock domain. Shares the single byte-wide write port between two requesters:
- A: single-byte producer (e.g. register-file read data).
- B: two-byte producer (e.g. 16-bit ALU result).

Grants round-robin, latches the request data, and issues FIFO writes only while the FIFO is not full. The two bytes of a B frame are always written back-to-back, never interleaved with an A byte.

Parameters:
- DATA_WIDTH, 8, width of one FIFO word; requester B supplies 2*DATA_WIDTH bits.

Ports:
- CLK  in  1  write-domain clock; same clock as the FIFO write side.
- RST_n  in  1  asynchronous active-low reset.
- req_a  in  1  requester A request; held high with data_a stable until gnt_a.
- data_a  in  DATA_WIDTH  requester A byte.
- gnt_a  out  1  one-cycle grant to A; data_a captured at this edge.
- req_b  in  1  requester B request; held high with data_b stable until gnt_b.
- data_b  in  2*DATA_WIDTH  requester B word; [DATA_WIDTH-1:0] is the low byte.
- gnt_b  out  1  one-cycle grant to B; data_b captured at this edge.
- wfull  in  1  FIFO full flag, already in this clock domain.
- winc  out  1  FIFO write strike.
- wdata  out  DATA_WIDTH  FIFO write data.
- busy  out  1  high whenever the arbiter is not in IDLE.

Behaviour:
- Reset (RST_n low, asynchronous):
  - state=IDLE, prio=A, hold_reg=0, src=A.
  - gnt_a=gnt_b=winc=busy=0, wdata=0.
  - Any in-flight frame is discarded; no partial write is resumed after reset.
- States: IDLE, WR_LO, WR_HI.
- IDLE:
  - Grant logic is Mealy and combinational, and active only in IDLE.
  - Only req_a high: gnt_a=1.
  - Only req_b high: gnt_b=1.
  - Both high: grant the requester named by prio.
  - On the grant edge:
    - latch the granted data into hold_reg (A: zero-extended);
    - record src;
    - set prio to the other requester;
    - next state = WR_LO.
  - No request: stay in IDLE, prio unchanged.
- WR_LO:
  - winc = !wfull; wdata = hold_reg[DATA_WIDTH-1:0].
  - wfull=1: stay in WR_LO, winc=0.
  - wfull=0: write happens this cycle; next state = WR_HI if src=B, else IDLE.
- WR_HI (B only):
  - winc = !wfull; wdata = hold_reg[2*DATA_WIDTH-1:DATA_WIDTH].
  - Stall while full; next state = IDLE on the write.
- winc is combinational from state and wfull. winc is never high in IDLE and never high while wfull=1.
- wdata:
  - WR_LO/WR_HI: driven from hold_reg by state.
  - IDLE: 0.
- gnt_x is high for exactly one cycle per accepted request, and never while busy=1.
- busy = (state != IDLE). Requests arriving while busy wait, with no loss, because requesters hold req until granted.
- Latency with no stalls:
  - A: grant cycle N, write cycle N+1, IDLE at N+2.
  - B: grant N, low byte N+1, high byte N+2, IDLE at N+3.
  - Each wfull cycle adds one cycle.
- Back-to-back: with both requests continuously high, grants alternate A,B,A,B…. The FIFO byte stream is A0,B0lo,B0hi,A1,B1lo,B1hi….
- wfull rising between the lo and hi bytes of B stalls in WR_HI. A requests stay blocked until the hi byte is written.
- Requester data changes after its grant edge have no effect on the bytes being written.

Test Plan:
- Reset, then req_a=1, data_a=8'h5A -> gnt_a=1 in the first cycle; the next cycle has winc=1, wdata=8'h5A; busy high for 1 cycle; back to IDLE.
- req_b=1, data_b=16'hBEEF, wfull=0 -> gnt_b pulse; winc on 2 consecutive cycles with wdata 8'hEF then 8'hBE.
- req_a and req_b both held high from reset, data_a=8'h11, data_b=16'h3322 -> FIFO sequence 11,22,33,11,22,33; gnt_a/gnt_b alternate starting with A.
- B granted with data_b=16'hA55A; wfull=1 for 3 cycles right after the lo-byte write -> winc stays 0 during the stall; 8'hA5 is written on the first cycle with wfull=0; the pending A is granted only afterwards.
- wfull=1 at the grant of A (data_a=8'h77) for 4 cycles -> no winc while full; exactly one write of 8'h77 when wfull drops; exactly one gnt_a.
- Assert RST_n low while in WR_HI -> all outputs 0 immediately; after release the held hi byte is never written; prio=A.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter sharing one FIFO write port between a
// single-byte requester (A) and a two-byte requester (B) whose bytes stay back-to-back.
module fifo_wr_arbiter #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                    CLK,
    input  logic                    RST_n,
    input  logic                    req_a,
    input  logic [DATA_WIDTH-1:0]   data_a,
    output logic                    gnt_a,
    input  logic                    req_b,
    input  logic [2*DATA_WIDTH-1:0] data_b,
    output logic                    gnt_b,
    input  logic                    wfull,
    output logic                    winc,
    output logic [DATA_WIDTH-1:0]   wdata,
    output logic                    busy
);
    typedef enum logic [1:0] {IDLE, WR_LO, WR_HI} state_t;

    state_t                  state_q, state_d;
    logic                    prio_q, prio_d;
    logic                    src_q, src_d;
    logic [2*DATA_WIDTH-1:0] hold_q, hold_d;

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_q <= IDLE;
            prio_q  <= 1'b0;
            src_q   <= 1'b0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            src_q   <= src_d;
            hold_q  <= hold_d;
        end
    end

    always_comb begin
        case (state_q)
            IDLE:    state_d = (gnt_a || gnt_b) ? WR_LO : IDLE;
            WR_LO:   state_d = wfull ? WR_LO : (src_q ? WR_HI : IDLE);
            WR_HI:   state_d = wfull ? WR_HI : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // prio/src: 0 names A, 1 names B; priority passes to whoever was not granted
    always_comb begin
        hold_d = gnt_a ? {{DATA_WIDTH{1'b0}}, data_a} : (gnt_b ? data_b : hold_q);
        src_d  = (gnt_a || gnt_b) ? gnt_b : src_q;
        prio_d = (gnt_a || gnt_b) ? gnt_a : prio_q;
    end

    // Grants are gated by reset so every output reads 0 while RST_n is low
    always_comb begin
        gnt_a = RST_n && (state_q == IDLE) && req_a && (!req_b || !prio_q);
        gnt_b = RST_n && (state_q == IDLE) && req_b && (!req_a || prio_q);
        winc  = ((state_q == WR_LO) || (state_q == WR_HI)) && !wfull;
        wdata = (state_q == WR_LO) ? hold_q[DATA_WIDTH-1:0] :
                (state_q == WR_HI) ? hold_q[2*DATA_WIDTH-1:DATA_WIDTH] : '0;
        busy  = (state_q != IDLE);
    end
endmodule
